c3aibadapt_sr_chain_ctrl: RTL and testbench
===========================================

Name: c3aibadapt_sr_chain_ctrl

Overview:
- Sequencer and serdes for the adapter's configuration/status shift-register chain.
- Drives the common sr_load strobe into a chain of CHAIN_LEN single-bit load/shift cells.
- Takes the serial output of the last cell and sends it as a framed serial stream.
- On the receive side, deserializes an inbound framed stream from the remote die into a parallel word with a valid strobe.

Parameters:
- CHAIN_LEN, 32, bits per frame and number of cells in the local chain; legal range 2..1024.
- GAP_CYCLES, 2, idle cycles between consecutive frames; legal range 0..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sr_enable  in  1  level; while high, frames repeat back-to-back, separated by the gap.
- sr_load  out  1  load strobe to all chain cells; 1 = capture parallel input, 0 = shift.
- sr_chain_out  in  1  serial output of the last chain cell.
- sr_ser_out  out  1  registered serial data to the remote die.
- sr_frame_out  out  1  high coincident with the first bit of each outbound frame.
- sr_ser_in  in  1  inbound serial data.
- sr_frame_in  in  1  inbound first-bit marker.
- sr_par_out  out  CHAIN_LEN  last completed inbound frame; the first received bit is the MSB.
- sr_par_valid  out  1  one-cycle pulse when sr_par_out updates.
- sr_frame_err  out  1  sticky framing error flag.
- sr_err_clr  in  1  clears sr_frame_err.

Behaviour:
- Reset (async): FSM=IDLE, all counters 0. Outputs after reset: sr_load=0, sr_ser_out=0, sr_frame_out=0, sr_par_out=0, sr_par_valid=0, sr_frame_err=0.
- Transmit FSM states and transitions:
  - IDLE: sr_load=0. Go to LOAD when sr_enable=1.
  - LOAD: sr_load=1 for exactly one cycle. Then go to SHIFT with bit_cnt=0.
  - SHIFT: sr_load=0 for CHAIN_LEN cycles (bit_cnt 0..CHAIN_LEN-1). Each edge registers sr_ser_out<=sr_chain_out and sr_frame_out<=(bit_cnt==0). After bit_cnt==CHAIN_LEN-1:
    - go to GAP if GAP_CYCLES>0;
    - else go to LOAD if sr_enable=1;
    - else go to IDLE.
  - GAP: counts GAP_CYCLES cycles with sr_frame_out=0, then goes to LOAD if sr_enable=1, else IDLE.
- Transmit timing:
  - Latency from the LOAD cycle to sr_frame_out=1 is 2 clocks.
  - sr_ser_out holds the last shifted value in GAP/IDLE. sr_frame_out is 0 outside the first bit.
  - A frame is one load plus CHAIN_LEN shifts, so the period is CHAIN_LEN+1+GAP_CYCLES cycles.
- sr_enable deasserted mid-frame: the current frame completes, then the FSM goes to IDLE. There is no truncation.
- Receive:
  - rx_cnt=0 means idle.
  - sr_frame_in=1 while rx_cnt==0: shift in sr_ser_in, rx_cnt=1.
  - rx_cnt in 1..CHAIN_LEN-1 with sr_frame_in=0: shift in sr_ser_in (rx_shift<={rx_shift[L-2:0],sr_ser_in}), rx_cnt++.
  - On the edge sampling bit CHAIN_LEN: sr_par_out<={rx_shift[L-2:0],sr_ser_in}, sr_par_valid=1 for that one cycle, rx_cnt=0.
  - With CHAIN_LEN=2, the shift on frame start is the only one before completion.
- Framing errors:
  - sr_frame_in=1 while rx_cnt in 1..CHAIN_LEN-1: set sr_frame_err. The partial frame is discarded and restarts with this bit as bit 1. No sr_par_valid.
  - sr_frame_in=0 while rx_cnt==0: the bit is ignored and no error is raised.
- sr_err_clr clears sr_frame_err. A simultaneous set and clear leaves the flag set.
- Transmit and receive are independent; either can run with the other idle.
- Reset mid-operation aborts both paths immediately. sr_par_out returns to 0.

Decomposition:
- Package c3aibadapt_sr_pkg:
  - transmit FSM state enum (IDLE, LOAD, SHIFT, GAP);
  - count-width helper (clog2 of CHAIN_LEN+1);
  - gap counter width constant (8).
- One sub-module, c3aibadapt_sr_deser: the receive path, owning rx_shift, rx_cnt, sr_par_out, sr_par_valid and sr_frame_err. The top holds the transmit FSM.

Test Plan:
- Setup for all scenarios: CHAIN_LEN=8, GAP_CYCLES=2. The bench models 8 load/shift cells (load input 0xA5), with sr_chain_out tied to the last cell and sr_ser_out/sr_frame_out looped back to sr_ser_in/sr_frame_in.
- Reset, then sr_enable=1 -> sr_load high exactly 1 cycle, sr_frame_out high 2 cycles later, sr_par_out=0xA5 with a single sr_par_valid pulse 8 cycles after the frame marker, sr_frame_err=0.
- sr_enable held high for 3 frames -> sr_load pulses spaced 11 cycles apart, three sr_par_valid pulses each with 0xA5.
- sr_enable dropped at SHIFT bit 3 -> frame completes with 8 bits, FSM enters GAP then IDLE, no further sr_load.
- Open loop: inject sr_frame_in=1 at bit 0 and again at bit 4, then 8 clean bits of 0x3C -> sr_frame_err=1 with no valid for the aborted frame, then sr_par_out=0x3C. Assert sr_err_clr together with a new error -> flag stays 1; clr alone -> flag 0.
- Assert rst_n low mid-SHIFT and mid-receive -> all outputs 0 asynchronously. After release, a clean frame of 0x81 is received correctly.
- GAP_CYCLES=0, sr_enable held high -> LOAD follows the last SHIFT immediately, giving a period of 9 cycles with no missing frames.

Source files
------------

// File: rtl/c3aibadapt_sr_pkg.sv
// c3aibadapt_sr_pkg: shared types and sizing helpers for the configuration shift-register chain controller
package c3aibadapt_sr_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} tx_state_e;
  localparam int GAP_W = 8;
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/c3aibadapt_sr_deser.sv
// c3aibadapt_sr_deser: receives a framed serial stream and presents it as a parallel word, MSB first
module c3aibadapt_sr_deser
  import c3aibadapt_sr_pkg::*;
#(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sr_ser_in,
  input  logic                 sr_frame_in,
  input  logic                 sr_err_clr,
  output logic [CHAIN_LEN-1:0] sr_par_out,
  output logic                 sr_par_valid,
  output logic                 sr_frame_err
);
  localparam int CW = cnt_w(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  logic [CHAIN_LEN-1:0] rx_shift_q, rx_shift_d, par_q, par_d, shifted;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic valid_q, valid_d, err_q, err_d, busy, done;
  always_comb begin
    busy = rx_cnt_q != '0;
    shifted = {rx_shift_q[CHAIN_LEN-2:0], sr_ser_in};
    done = busy && !sr_frame_in && rx_cnt_q == LAST;
    rx_shift_d = (sr_frame_in || busy) ? shifted : rx_shift_q;
    // a marker always (re)starts a frame at bit 1, dropping any partial frame
    rx_cnt_d = sr_frame_in ? CW'(1) : done ? '0 : busy ? rx_cnt_q + 1'b1 : rx_cnt_q;
    par_d = done ? shifted : par_q;
    valid_d = done;
    err_d = (sr_frame_in && busy) || (err_q && !sr_err_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_q <= '0;
      rx_cnt_q <= '0;
      par_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_cnt_q <= rx_cnt_d;
      par_q <= par_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign sr_par_out = par_q;
  assign sr_par_valid = valid_q;
  assign sr_frame_err = err_q;
endmodule

// File: rtl/c3aibadapt_sr_chain_ctrl.sv
// c3aibadapt_sr_chain_ctrl: load/shift sequencer for the local chain, framed serial transmit,
// and framed serial receive of the remote chain
module c3aibadapt_sr_chain_ctrl
  import c3aibadapt_sr_pkg::*;
#(
  parameter int CHAIN_LEN  = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sr_enable,
  output logic                 sr_load,
  input  logic                 sr_chain_out,
  output logic                 sr_ser_out,
  output logic                 sr_frame_out,
  input  logic                 sr_ser_in,
  input  logic                 sr_frame_in,
  output logic [CHAIN_LEN-1:0] sr_par_out,
  output logic                 sr_par_valid,
  output logic                 sr_frame_err,
  input  logic                 sr_err_clr
);
  localparam int CW = cnt_w(CHAIN_LEN);
  localparam logic [CW-1:0] BIT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  tx_state_e state_q, state_d, after_frame;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic load_q, load_d, ser_q, ser_d, frame_q, frame_d;
  always_comb begin
    after_frame = sr_enable ? LOAD : IDLE;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = after_frame;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == BIT_LAST) state_d = GAP_CYCLES > 0 ? GAP : after_frame;
      GAP:     if (gap_cnt_q == GAP_LAST) state_d = after_frame;
      default: state_d = IDLE;
    endcase
    bit_cnt_d = state_q == SHIFT ? bit_cnt_q + 1'b1 : '0;
    gap_cnt_d = state_q == GAP ? gap_cnt_q + 1'b1 : '0;
    // sr_load is registered from the next state so it is high throughout the LOAD cycle
    load_d = state_d == LOAD;
    ser_d = state_q == SHIFT ? sr_chain_out : ser_q;
    frame_d = state_q == SHIFT && bit_cnt_q == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      load_q <= 1'b0;
      ser_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      load_q <= load_d;
      ser_q <= ser_d;
      frame_q <= frame_d;
    end
  end
  assign sr_load = load_q;
  assign sr_ser_out = ser_q;
  assign sr_frame_out = frame_q;
  c3aibadapt_sr_deser #(.CHAIN_LEN(CHAIN_LEN)) u_deser (
    .clk          (clk),
    .rst_n        (rst_n),
    .sr_ser_in    (sr_ser_in),
    .sr_frame_in  (sr_frame_in),
    .sr_err_clr   (sr_err_clr),
    .sr_par_out   (sr_par_out),
    .sr_par_valid (sr_par_valid),
    .sr_frame_err (sr_frame_err)
  );
endmodule

// File: tb/tb_c3aibadapt_sr_chain_ctrl.sv
// tb_c3aibadapt_sr_chain_ctrl: directed loopback and open-loop checks of the SR chain controller
module tb_c3aibadapt_sr_chain_ctrl;
  import c3aibadapt_sr_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic en = 1'b0, loop = 1'b1, drv_ser = 1'b0, drv_frame = 1'b0, err_clr = 1'b0, en0 = 1'b0;
  logic [7:0] load_val = 8'hA5, cells, cells0, sr_par_out, par0;
  logic sr_load, sr_ser_out, sr_frame_out, sr_par_valid, sr_frame_err;
  logic load0, ser0, frame0, valid0, err0;
  int n_cmp = 0, n_err = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cells <= '0;
    else cells <= sr_load ? load_val : {cells[6:0], 1'b0};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cells0 <= '0;
    else cells0 <= load0 ? 8'hA5 : {cells0[6:0], 1'b0};
  c3aibadapt_sr_chain_ctrl #(.CHAIN_LEN(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sr_enable(en), .sr_load(sr_load), .sr_chain_out(cells[7]),
    .sr_ser_out(sr_ser_out), .sr_frame_out(sr_frame_out),
    .sr_ser_in(loop ? sr_ser_out : drv_ser), .sr_frame_in(loop ? sr_frame_out : drv_frame),
    .sr_par_out(sr_par_out), .sr_par_valid(sr_par_valid), .sr_frame_err(sr_frame_err),
    .sr_err_clr(err_clr)
  );
  c3aibadapt_sr_chain_ctrl #(.CHAIN_LEN(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sr_enable(en0), .sr_load(load0), .sr_chain_out(cells0[7]),
    .sr_ser_out(ser0), .sr_frame_out(frame0), .sr_ser_in(ser0), .sr_frame_in(frame0),
    .sr_par_out(par0), .sr_par_valid(valid0), .sr_frame_err(err0), .sr_err_clr(1'b0)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({sr_load, sr_ser_out, sr_frame_out, sr_par_valid, sr_frame_err, sr_par_out} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", {sr_load, sr_ser_out, sr_frame_out, sr_par_valid, sr_frame_err, sr_par_out});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (sr_load !== 1'b0) begin n_err++; $display("FAIL idle_no_load: got %b want 0", sr_load); end
  endtask

  task automatic test_single_frame();
    int nl, nf, nv, load_at, frame_at, valid_at;
    logic [7:0] par;
    nl = 0; nf = 0; nv = 0; load_at = 0; frame_at = 0; valid_at = 0; par = '0;
    en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) en = 1'b0;
      if (sr_load) begin nl++; load_at = c; end
      if (sr_frame_out) begin nf++; frame_at = c; end
      if (sr_par_valid) begin nv++; valid_at = c; par = sr_par_out; end
    end
    n_cmp++;
    if (nl != 1 || load_at != 1) begin n_err++; $display("FAIL single_load: got %0d pulses at %0d want 1 at 1", nl, load_at); end
    n_cmp++;
    if (nf != 1 || frame_at != 3) begin n_err++; $display("FAIL single_frame_mark: got %0d at %0d want 1 at 3", nf, frame_at); end
    n_cmp++;
    if (nv != 1 || valid_at != 11) begin n_err++; $display("FAIL single_valid: got %0d at %0d want 1 at 11", nv, valid_at); end
    n_cmp++;
    if (par !== 8'hA5) begin n_err++; $display("FAIL single_par: got %h want a5", par); end
    n_cmp++;
    if (sr_frame_err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", sr_frame_err); end
  endtask

  task automatic test_back_to_back();
    int nl, nv, lt[3];
    logic [7:0] pars[3];
    nl = 0; nv = 0;
    en = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (sr_load) begin if (nl < 3) lt[nl] = c; nl++; end
      if (sr_par_valid) begin if (nv < 3) pars[nv] = sr_par_out; nv++; end
      if (c == 23) en = 1'b0;
    end
    n_cmp++;
    if (nl != 3) begin n_err++; $display("FAIL b2b_load_count: got %0d want 3", nl); end
    n_cmp++;
    if (lt[1] - lt[0] != 11 || lt[2] - lt[1] != 11) begin
      n_err++; $display("FAIL b2b_period: got %0d,%0d want 11,11", lt[1] - lt[0], lt[2] - lt[1]);
    end
    n_cmp++;
    if (nv != 3) begin n_err++; $display("FAIL b2b_valid_count: got %0d want 3", nv); end
    for (int i = 0; i < 3 && i < nv; i++) begin
      n_cmp++;
      if (pars[i] !== 8'hA5) begin n_err++; $display("FAIL b2b_par%0d: got %h want a5", i, pars[i]); end
    end
  endtask

  task automatic test_enable_drop();
    int nl, nv;
    logic [7:0] par;
    nl = 0; nv = 0; par = '0;
    en = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 5) en = 1'b0;
      if (sr_load) nl++;
      if (sr_par_valid) begin nv++; par = sr_par_out; end
      if (c == 10) begin
        n_cmp++;
        if (dut.state_q !== GAP) begin n_err++; $display("FAIL drop_gap_state: got %0d want %0d", dut.state_q, GAP); end
      end
      if (c == 12) begin
        n_cmp++;
        if (dut.state_q !== IDLE) begin n_err++; $display("FAIL drop_idle_state: got %0d want %0d", dut.state_q, IDLE); end
      end
    end
    n_cmp++;
    if (nl != 1) begin n_err++; $display("FAIL drop_loads: got %0d want 1", nl); end
    n_cmp++;
    if (nv != 1 || par !== 8'hA5) begin n_err++; $display("FAIL drop_frame: got %0d valid par %h want 1 a5", nv, par); end
  endtask

  task automatic test_open_loop();
    int nv;
    logic [7:0] pat;
    nv = 0; pat = 8'h3C;
    loop = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      drv_frame = (k == 0 || k == 4 || k == 5);
      drv_ser = k < 5 ? 1'b1 : pat[12-k];
      tick();
      if (sr_par_valid) nv++;
      if (k == 4) begin
        n_cmp++;
        if (sr_frame_err !== 1'b1) begin n_err++; $display("FAIL open_err_set: got %b want 1", sr_frame_err); end
      end
    end
    n_cmp++;
    if (nv != 1 || sr_par_valid !== 1'b1) begin n_err++; $display("FAIL open_valid: got %0d pulses last %b want 1 1", nv, sr_par_valid); end
    n_cmp++;
    if (sr_par_out !== 8'h3C) begin n_err++; $display("FAIL open_par: got %h want 3c", sr_par_out); end
    drv_frame = 1'b0;
    tick();
    n_cmp++;
    if (sr_par_valid !== 1'b0) begin n_err++; $display("FAIL open_valid_pulse: got %b want 0", sr_par_valid); end
  endtask

  task automatic test_err_clr();
    int nv;
    nv = 0;
    drv_frame = 1'b0; drv_ser = 1'b1; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    repeat (3) begin tick(); if (sr_par_valid) nv++; end
    n_cmp++;
    if (sr_frame_err !== 1'b0 || nv != 0) begin n_err++; $display("FAIL clr_and_stray_bits: got err %b valid %0d want 0 0", sr_frame_err, nv); end
    drv_frame = 1'b1;
    tick();
    err_clr = 1'b1;
    tick();
    n_cmp++;
    if (sr_frame_err !== 1'b1) begin n_err++; $display("FAIL set_with_clr: got %b want 1", sr_frame_err); end
    drv_frame = 1'b0;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (sr_frame_err !== 1'b0) begin n_err++; $display("FAIL clr_alone: got %b want 0", sr_frame_err); end
  endtask

  task automatic test_async_reset();
    int nv, valid_at;
    logic [7:0] par;
    nv = 0; valid_at = 0; par = '0;
    loop = 1'b1; en = 1'b1;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sr_load, sr_ser_out, sr_frame_out, sr_par_valid, sr_frame_err, sr_par_out} !== 13'h0) begin
      n_err++;
      $display("FAIL async_reset: got %b want 0", {sr_load, sr_ser_out, sr_frame_out, sr_par_valid, sr_frame_err, sr_par_out});
    end
    en = 1'b0; load_val = 8'h81;
    tick();
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) en = 1'b0;
      if (sr_par_valid) begin nv++; valid_at = c; par = sr_par_out; end
    end
    n_cmp++;
    if (nv != 1 || valid_at != 11) begin n_err++; $display("FAIL post_reset_valid: got %0d at %0d want 1 at 11", nv, valid_at); end
    n_cmp++;
    if (par !== 8'h81) begin n_err++; $display("FAIL post_reset_par: got %h want 81", par); end
  endtask

  task automatic test_gap0();
    int nl, nv, lt[3];
    logic [7:0] pars[3];
    nl = 0; nv = 0;
    en0 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (load0) begin if (nl < 3) lt[nl] = c; nl++; end
      if (valid0) begin if (nv < 3) pars[nv] = par0; nv++; end
      if (nl == 3) en0 = 1'b0;
    end
    n_cmp++;
    if (nl != 3 || lt[0] != 1) begin n_err++; $display("FAIL gap0_loads: got %0d first at %0d want 3 first at 1", nl, lt[0]); end
    n_cmp++;
    if (lt[1] - lt[0] != 9 || lt[2] - lt[1] != 9) begin
      n_err++; $display("FAIL gap0_period: got %0d,%0d want 9,9", lt[1] - lt[0], lt[2] - lt[1]);
    end
    n_cmp++;
    if (nv != 3) begin n_err++; $display("FAIL gap0_valid_count: got %0d want 3", nv); end
    for (int i = 0; i < 3 && i < nv; i++) begin
      n_cmp++;
      if (pars[i] !== 8'hA5) begin n_err++; $display("FAIL gap0_par%0d: got %h want a5", i, pars[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable_drop();
    test_open_loop();
    test_err_clr();
    test_async_reset();
    test_gap0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
